// File: rtl/mips_pkg.sv
// Shared definitions for the 32-bit MIPS core: opcodes, fetch FSM encoding and reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [0:0] IFU_FETCH = 1'b0;
    localparam logic [0:0] IFU_EXEC  = 1'b1;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the fetch unit: PC+4, BEQ target or J target (Jump has priority).
module pc_next_logic #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [25:0]           instrField,
    input  logic                  jump,
    input  logic                  branch,
    input  logic                  zero,
    output logic [ADDR_WIDTH-1:0] pcPlus4,
    output logic [ADDR_WIDTH-1:0] nextPc
);

    logic [ADDR_WIDTH-1:0] branchOffset;
    logic [ADDR_WIDTH-1:0] branchTarget;
    logic [ADDR_WIDTH-1:0] jumpTarget;

    // All additions are modulo 2^ADDR_WIDTH; carries out are intentionally dropped.
    assign pcPlus4      = pc + ADDR_WIDTH'(4);
    assign branchOffset = {{(ADDR_WIDTH-18){instrField[15]}}, instrField[15:0], 2'b00};
    assign branchTarget = pcPlus4 + branchOffset;
    assign jumpTarget   = {pcPlus4[ADDR_WIDTH-1:28], instrField[25:0], 2'b00};

    always_comb begin
        nextPc = pcPlus4;
        if (jump) begin
            nextPc = jumpTarget;
        end else if (branch && zero) begin
            nextPc = branchTarget;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC/IR registers and a FETCH/EXEC handshake FSM with instruction memory.
// Optional performance counters are compiled in with macro IFU_PERF_CNT_EN.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IFU_Stall,
    input  logic                  IFU_Jump,
    input  logic                  IFU_Branch,
    input  logic                  IFU_Zero,
    output logic                  IFU_IMemReq,
    output logic [ADDR_WIDTH-1:0] IFU_IMemAddr,
    input  logic                  IFU_IMemAck,
    input  logic [DATA_WIDTH-1:0] IFU_IMemRdata,
    output logic [DATA_WIDTH-1:0] IFU_Instr,
    output logic [5:0]            IFU_Opcode,
    output logic [5:0]            IFU_Funct,
    output logic [ADDR_WIDTH-1:0] IFU_PC,
    output logic [ADDR_WIDTH-1:0] IFU_PCPlus4,
    output logic                  IFU_Valid
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           IFU_RetireCnt,
    output logic [31:0]           IFU_TakenCnt
`endif
);

    logic [0:0]            stateReg;
    logic                  reqReg;
    logic [ADDR_WIDTH-1:0] pcReg;
    logic [DATA_WIDTH-1:0] instrReg;
    logic [ADDR_WIDTH-1:0] nextPc;
    logic                  commit;

    pc_next_logic #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uPcNext (
        .pc         (pcReg),
        .instrField (instrReg[25:0]),
        .jump       (IFU_Jump),
        .branch     (IFU_Branch),
        .zero       (IFU_Zero),
        .pcPlus4    (IFU_PCPlus4),
        .nextPc     (nextPc)
    );

    assign IFU_Valid = (stateReg == IFU_EXEC);
    assign commit    = IFU_Valid && !IFU_Stall;

    // Req is registered; it is also 0 in the first FETCH cycle after reset, so acks then are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateReg <= IFU_FETCH;
            reqReg   <= 1'b0;
            pcReg    <= RESET_PC;
            instrReg <= '0;
        end else begin
            case (stateReg)
                IFU_FETCH: begin
                    if (reqReg && IFU_IMemAck) begin
                        instrReg <= IFU_IMemRdata;
                        stateReg <= IFU_EXEC;
                        reqReg   <= 1'b0;
                    end else begin
                        reqReg   <= 1'b1;
                    end
                end
                IFU_EXEC: begin
                    if (commit) begin
                        pcReg    <= nextPc;
                        stateReg <= IFU_FETCH;
                        reqReg   <= 1'b1;
                    end
                end
                default: begin
                    stateReg <= IFU_FETCH;
                    reqReg   <= 1'b0;
                end
            endcase
        end
    end

    assign IFU_IMemReq  = reqReg;
    assign IFU_IMemAddr = pcReg;
    assign IFU_PC       = pcReg;
    assign IFU_Instr    = instrReg;
    assign IFU_Opcode   = instrReg[31:26];
    assign IFU_Funct    = instrReg[5:0];

`ifdef IFU_PERF_CNT_EN
    logic        taken;
    logic [31:0] retireCntReg;
    logic [31:0] takenCntReg;

    assign taken = IFU_Jump || (IFU_Branch && IFU_Zero);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retireCntReg <= '0;
            takenCntReg  <= '0;
        end else if (commit) begin
            retireCntReg <= retireCntReg + 32'd1;
            if (taken) begin
                takenCntReg <= takenCntReg + 32'd1;
            end
        end
    end

    assign IFU_RetireCnt = retireCntReg;
    assign IFU_TakenCnt  = takenCntReg;
`else
    // Counters absent: fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (counters checked when IFU_PERF_CNT_EN is defined).
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IFU_Stall, IFU_Jump, IFU_Branch, IFU_Zero;
    logic        IFU_IMemReq;
    logic [31:0] IFU_IMemAddr;
    logic        IFU_IMemAck;
    logic [31:0] IFU_IMemRdata;
    logic [31:0] IFU_Instr;
    logic [5:0]  IFU_Opcode, IFU_Funct;
    logic [31:0] IFU_PC, IFU_PCPlus4;
    logic        IFU_Valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] IFU_RetireCnt, IFU_TakenCnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK           (CLK),
        .RST           (RST),
        .IFU_Stall     (IFU_Stall),
        .IFU_Jump      (IFU_Jump),
        .IFU_Branch    (IFU_Branch),
        .IFU_Zero      (IFU_Zero),
        .IFU_IMemReq   (IFU_IMemReq),
        .IFU_IMemAddr  (IFU_IMemAddr),
        .IFU_IMemAck   (IFU_IMemAck),
        .IFU_IMemRdata (IFU_IMemRdata),
        .IFU_Instr     (IFU_Instr),
        .IFU_Opcode    (IFU_Opcode),
        .IFU_Funct     (IFU_Funct),
        .IFU_PC        (IFU_PC),
        .IFU_PCPlus4   (IFU_PCPlus4),
        .IFU_Valid     (IFU_Valid)
`ifdef IFU_PERF_CNT_EN
        ,
        .IFU_RetireCnt (IFU_RetireCnt),
        .IFU_TakenCnt  (IFU_TakenCnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold Ack low for waitCycles cycles with Req asserted, then ack with rdata.
    task automatic doFetch(input logic [31:0] rdata, input int waitCycles, input logic [31:0] expPc);
        logic [31:0] w;
        w = rdata;
        for (int i = 0; i < waitCycles; i++) begin
            check("req_wait", {31'd0, IFU_IMemReq}, 32'd1);
            check("valid_wait", {31'd0, IFU_Valid}, 32'd0);
            tick();
        end
        check("fetch_addr", IFU_IMemAddr, expPc);
        check("fetch_req", {31'd0, IFU_IMemReq}, 32'd1);
        IFU_IMemAck   = 1'b1;
        IFU_IMemRdata = rdata;
        tick();
        IFU_IMemAck   = 1'b0;
        IFU_IMemRdata = 32'hFFFF_FFFF;
        check("exec_valid", {31'd0, IFU_Valid}, 32'd1);
        check("exec_req", {31'd0, IFU_IMemReq}, 32'd0);
        check("ir", IFU_Instr, rdata);
        check("opcode", {26'd0, IFU_Opcode}, {26'd0, w[31:26]});
        check("funct", {26'd0, IFU_Funct}, {26'd0, w[5:0]});
        $display("fetch pc=%h ir=%h wait=%0d", expPc, rdata, waitCycles);
    endtask

    task automatic doCommit(input logic j, input logic b, input logic z,
                            input logic [31:0] expPlus4, input logic [31:0] expNext);
        IFU_Jump   = j;
        IFU_Branch = b;
        IFU_Zero   = z;
        #1;
        check("pcplus4", IFU_PCPlus4, expPlus4);
        tick();
        IFU_Jump   = 1'b0;
        IFU_Branch = 1'b0;
        IFU_Zero   = 1'b0;
        check("next_pc", IFU_PC, expNext);
        check("next_addr", IFU_IMemAddr, expNext);
        check("commit_valid", {31'd0, IFU_Valid}, 32'd0);
        check("commit_req", {31'd0, IFU_IMemReq}, 32'd1);
        $display("commit j=%b b=%b z=%b next_pc=%h", j, b, z, expNext);
    endtask

    initial begin
        RST = 1'b1;
        IFU_Stall = 1'b0; IFU_Jump = 1'b0; IFU_Branch = 1'b0; IFU_Zero = 1'b0;
        IFU_IMemAck = 1'b0; IFU_IMemRdata = 32'h0;
        #2;
        check("rst_req", {31'd0, IFU_IMemReq}, 32'd0);
        check("rst_valid", {31'd0, IFU_Valid}, 32'd0);
        check("rst_pc", IFU_PC, 32'h0);
        check("rst_ir", IFU_Instr, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check("rst_retire", IFU_RetireCnt, 32'd0);
        check("rst_taken", IFU_TakenCnt, 32'd0);
`endif
        tick();
        tick();
        RST = 1'b0;
        check("req_low_before_edge", {31'd0, IFU_IMemReq}, 32'd0);
        tick();
        check("req_rises", {31'd0, IFU_IMemReq}, 32'd1);

        // Test 1: addi, zero-wait, straight-line
        doFetch(32'h2008_0005, 0, 32'h0);
        doCommit(1'b0, 1'b0, 1'b0, 32'h4, 32'h4);
        // Move to 0x10 with a jump
        doFetch(32'h0800_0004, 0, 32'h4);
        doCommit(1'b1, 1'b0, 1'b0, 32'h8, 32'h10);
        // Test 2: beq taken and not taken
        doFetch(32'h1000_0003, 0, 32'h10);
        doCommit(1'b0, 1'b1, 1'b1, 32'h14, 32'h20);
        doFetch(32'h0800_0004, 0, 32'h20);
        doCommit(1'b1, 1'b0, 1'b0, 32'h24, 32'h10);
        doFetch(32'h1000_0003, 0, 32'h10);
        doCommit(1'b0, 1'b1, 1'b0, 32'h14, 32'h14);
        // Reach 0x1000_0040 via region boundary: j to 0x0FFF_FFFC, then j into region 1
        doFetch(32'h0BFF_FFFF, 0, 32'h14);
        doCommit(1'b1, 1'b0, 1'b0, 32'h18, 32'h0FFF_FFFC);
        doFetch(32'h0800_0010, 0, 32'h0FFF_FFFC);
        doCommit(1'b1, 1'b0, 1'b0, 32'h1000_0000, 32'h1000_0040);
        // Test 3: Jump and Branch both high, Jump wins
        doFetch(32'h0800_0100, 0, 32'h1000_0040);
        doCommit(1'b1, 1'b1, 1'b1, 32'h1000_0044, 32'h1000_0400);

        // Test 4: ack delayed 3 cycles, stall 2 cycles with stray ack
        doFetch(32'h2008_0001, 3, 32'h1000_0400);
        IFU_Stall     = 1'b1;
        IFU_IMemAck   = 1'b1;
        IFU_IMemRdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_ir", IFU_Instr, 32'h2008_0001);
            check("stall_pc", IFU_PC, 32'h1000_0400);
            check("stall_valid", {31'd0, IFU_Valid}, 32'd1);
            check("stall_req", {31'd0, IFU_IMemReq}, 32'd0);
            $display("stall cycle %0d pc=%h ir=%h", i, IFU_PC, IFU_Instr);
        end
        IFU_Stall   = 1'b0;
        IFU_IMemAck = 1'b0;
        doCommit(1'b0, 1'b0, 1'b0, 32'h1000_0404, 32'h1000_0404);

        // Test 5: reset while Req=1 with an ack in the same cycle
        IFU_IMemAck   = 1'b1;
        IFU_IMemRdata = 32'h1234_5678;
        #2;
        RST = 1'b1;
        #1;
        check("midrst_req", {31'd0, IFU_IMemReq}, 32'd0);
        check("midrst_valid", {31'd0, IFU_Valid}, 32'd0);
        check("midrst_pc", IFU_PC, 32'h0);
        check("midrst_ir", IFU_Instr, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check("midrst_retire", IFU_RetireCnt, 32'd0);
`endif
        tick();
        check("rsthold_ir", IFU_Instr, 32'h0);
        IFU_IMemAck = 1'b0;
        RST = 1'b0;
        $display("reset pulse pc=%h req=%b", IFU_PC, IFU_IMemReq);
        tick();
        check("refetch_req", {31'd0, IFU_IMemReq}, 32'd1);
        check("refetch_valid", {31'd0, IFU_Valid}, 32'd0);

        // Test 6: backward beq wraps to 0xFFFF_FFFC, then PC+4 wraps to 0
        doFetch(32'h1000_FFFE, 0, 32'h0);
        doCommit(1'b0, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFC);
        doFetch(32'h2008_0002, 0, 32'hFFFF_FFFC);
        doCommit(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        doFetch(32'h2008_0003, 0, 32'h0);
        IFU_Stall = 1'b1;
        tick();
`ifdef IFU_PERF_CNT_EN
        check("stall_retire", IFU_RetireCnt, 32'd2);
        check("stall_taken", IFU_TakenCnt, 32'd1);
`endif
        check("stall2_valid", {31'd0, IFU_Valid}, 32'd1);
        IFU_Stall = 1'b0;
        doCommit(1'b0, 1'b0, 1'b0, 32'h4, 32'h4);
`ifdef IFU_PERF_CNT_EN
        check("retire_cnt", IFU_RetireCnt, 32'd3);
        check("taken_cnt", IFU_TakenCnt, 32'd1);
        $display("counters retire=%0d taken=%0d", IFU_RetireCnt, IFU_TakenCnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
